// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared widths and lane helpers for the systolic array datapath
package systolic_pkg;

   // Default processing-element accumulator width and array width.
   localparam int ACCUMULATOR_WIDTH_DEF = 32;
   localparam int COLS_DEF              = 4;

   // Bit offset of a column lane inside a packed bottom-row bus.
   function automatic int lane_lsb(input int lane, input int aw);
      return lane * aw;
   endfunction

   // Counter width that never collapses to zero bits.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock row FIFO with registered storage and occupancy count
module sync_fifo
   import systolic_pkg::*;
#(
   parameter int WIDTH = 129,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     arst,
   input  logic                     srst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_pop  = pop & ~empty;
   // A write into a full FIFO only lands when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   // Head entry read straight from storage; nothing from the write side reaches it.
   assign rdata   = mem_q[rd_ptr_q];

   // Next occupancy from the accepted push/pop pair.
   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointers and occupancy; pointer width makes the wrap modulo DEPTH implicit.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (srst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   // Storage is cleared too so the presented row reads as zero after reset.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      end else if (srst) begin
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

// File: rtl/systolic_output_collector.sv
// rtl/systolic_output_collector.sv - deskews the bottom array row into whole rows and streams them out
module systolic_output_collector
   import systolic_pkg::*;
#(
   parameter int COLS              = COLS_DEF,
   parameter int ACCUMULATOR_WIDTH = ACCUMULATOR_WIDTH_DEF,
   parameter int ROWS_PER_TILE     = 4,
   parameter int FIFO_DEPTH        = 8
) (
   input  logic                              CLK,
   input  logic                              ASYNC_RST,
   input  logic                              SYNC_RST,
   input  logic                              EN,
   input  logic                              IN_VALID,
   input  logic [COLS*ACCUMULATOR_WIDTH-1:0] PSUM_IN,
   output logic [COLS*ACCUMULATOR_WIDTH-1:0] OUT_DATA,
   output logic                              OUT_VALID,
   output logic                              OUT_LAST,
   input  logic                              OUT_READY,
   output logic                              STALL,
   output logic                              OVERFLOW
);

   localparam int AW  = ACCUMULATOR_WIDTH;
   localparam int DW  = COLS * AW;
   localparam int RCW = cnt_width(ROWS_PER_TILE);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;

   logic [COLS-2:0] vpipe_q;
   logic [COLS-2:0] vpipe_d;
   logic [DW-1:0]   aligned_row;
   logic            row_push;
   logic            row_last;
   logic [RCW-1:0]  row_cnt_q;
   logic [RCW-1:0]  row_cnt_d;
   logic            overflow_q;
   logic            overflow_d;
   logic [DW:0]     fifo_rdata;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;

   // Valid marker shifts one stage per enabled cycle, entering at stage 0.
   always_comb begin
      vpipe_d    = vpipe_q;
      vpipe_d[0] = IN_VALID;
      for (int k = 1; k < COLS - 1; k++) vpipe_d[k] = vpipe_q[k-1];
   end

   // Valid pipe freezes with the array when EN is low.
   always_ff @(posedge CLK or posedge ASYNC_RST) begin
      if (ASYNC_RST) begin
         vpipe_q <= '0;
      end else if (SYNC_RST) begin
         vpipe_q <= '0;
      end else if (EN) begin
         vpipe_q <= vpipe_d;
      end
   end

   // Lane c arrives c cycles late, so it is held back COLS-1-c stages to line up with the last lane.
   for (genvar c = 0; c < COLS; c++) begin : g_lane
      localparam int D   = COLS - 1 - c;
      localparam int LSB = lane_lsb(c, AW);
      if (D == 0) begin : g_direct
         assign aligned_row[LSB +: AW] = PSUM_IN[LSB +: AW];
      end else begin : g_pipe
         logic [AW-1:0] pipe_q [D];
         // Lane delay line, frozen together with the valid pipe.
         always_ff @(posedge CLK or posedge ASYNC_RST) begin
            if (ASYNC_RST) begin
               for (int k = 0; k < D; k++) pipe_q[k] <= '0;
            end else if (SYNC_RST) begin
               for (int k = 0; k < D; k++) pipe_q[k] <= '0;
            end else if (EN) begin
               pipe_q[0] <= PSUM_IN[LSB +: AW];
               for (int k = 1; k < D; k++) pipe_q[k] <= pipe_q[k-1];
            end
         end
         assign aligned_row[LSB +: AW] = pipe_q[D-1];
      end
   end

   assign row_push = EN & vpipe_q[COLS-2];
   assign row_last = (row_cnt_q == RCW'(ROWS_PER_TILE - 1));

   // Row position within the tile advances on every aligned row, kept or dropped.
   always_comb begin
      row_cnt_d = row_cnt_q;
      if (row_push) begin
         row_cnt_d = row_last ? '0 : row_cnt_q + 1'b1;
      end
   end

   // A drop needs a full FIFO with no departing head this cycle.
   always_comb begin
      overflow_d = overflow_q;
      if (row_push && fifo_full && !OUT_READY) overflow_d = 1'b1;
   end

   // Row counter and sticky overflow flag.
   always_ff @(posedge CLK or posedge ASYNC_RST) begin
      if (ASYNC_RST) begin
         row_cnt_q  <= '0;
         overflow_q <= 1'b0;
      end else if (SYNC_RST) begin
         row_cnt_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         row_cnt_q  <= row_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   sync_fifo #(
      .WIDTH (DW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (CLK),
      .arst  (ASYNC_RST),
      .srst  (SYNC_RST),
      .push  (row_push),
      .wdata ({row_last, aligned_row}),
      .pop   (OUT_READY),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign OUT_VALID = ~fifo_empty;
   assign OUT_DATA  = fifo_rdata[DW-1:0];
   assign OUT_LAST  = fifo_rdata[DW];
   assign OVERFLOW  = overflow_q;
   // Headroom of COLS rows absorbs rows already inside the deskew pipes plus the controller's reaction cycle.
   assign STALL     = (fifo_count >= CW'(FIFO_DEPTH - COLS));

endmodule
